// File: rtl/frame_param_pkg.sv
// frame_param_pkg: channel map, default reset values and a width helper for the parameter shadow bank
package frame_param_pkg;
  localparam int CH_X_LEN     = 0;
  localparam int CH_Y_LEN     = 1;
  localparam int CH_BI_A      = 2;
  localparam int CH_OUT_MODEL = 3;
  localparam logic [11:0] DEF_X_LEN     = 12'd1920;
  localparam logic [11:0] DEF_Y_LEN     = 12'd1080;
  localparam logic [11:0] DEF_BI_A      = 12'd128;
  localparam logic [11:0] DEF_OUT_MODEL = 12'd1;
  localparam logic [47:0] DEF_RESET_VAL = {DEF_OUT_MODEL, DEF_BI_A, DEF_Y_LEN, DEF_X_LEN};
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/vs_edge_delay.sv
// vs_edge_delay: vsync edge detect plus a SYNC_DLY-deep delay line
//   clk, rst_n : clock, async active-low reset
//   vsync      : frame sync, synchronous to clk
//   raw_ev     : selected vsync edge seen this cycle (registered at edge k)
//   apply_ev   : same event SYNC_DLY cycles later (acts at edge k+SYNC_DLY)
module vs_edge_delay #(
  parameter int SYNC_DLY = 3,
  parameter bit VS_POL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  output logic raw_ev,
  output logic apply_ev
);
  logic vs_d;
  logic [SYNC_DLY-1:0] dly;
  assign raw_ev   = VS_POL ? (vsync & ~vs_d) : (~vsync & vs_d);
  assign apply_ev = dly[SYNC_DLY-1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vs_d <= 1'b0;
      dly  <= '0;
    end else begin
      vs_d <= vsync;
      dly  <= SYNC_DLY'({dly, raw_ev});
    end
endmodule

// File: rtl/frame_param_shadow.sv
// frame_param_shadow: staging/shadow parameter bank applied atomically after a delayed vsync edge
//   sys_clk, sys_rst_n      : clock, async active-low reset
//   vsync_i                 : frame sync from the scaler output
//   wr_req_i/wr_ch_i/wr_data_i, wr_ack_o : staging write and its one-cycle ack
//   commit_req_i, commit_pend_o         : mark staging ready / commit not yet applied
//   shadow_data_o, update_pulse_o       : applied set (ch0 in LSBs) / pulse on change
//   frame_cnt_o, timeout_o              : delayed vsync count / last apply forced by watchdog
module frame_param_shadow
  import frame_param_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 12,
  parameter int SYNC_DLY = 3,
  parameter bit VS_POL   = 1'b0,
  parameter int TO_W     = 24,
  parameter logic [TO_W-1:0] TIMEOUT = 24'd3_000_000,
  parameter logic [NUM_CH*DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic                       vsync_i,
  input  logic                       wr_req_i,
  input  logic [clog2(NUM_CH)-1:0]   wr_ch_i,
  input  logic [DATA_W-1:0]          wr_data_i,
  output logic                       wr_ack_o,
  input  logic                       commit_req_i,
  output logic                       commit_pend_o,
  output logic [NUM_CH*DATA_W-1:0]   shadow_data_o,
  output logic                       update_pulse_o,
  output logic [15:0]                frame_cnt_o,
  output logic                       timeout_o
);
  localparam bit WD_EN = TIMEOUT != '0;
  localparam logic [TO_W-1:0] TO_MAX = TIMEOUT - 1'b1;
  logic [NUM_CH-1:0][DATA_W-1:0] stg, shd;
  logic raw_ev, apply_ev, force_ev, do_apply, wr_ok, pend;
  logic [TO_W-1:0] wd;
  vs_edge_delay #(.SYNC_DLY(SYNC_DLY), .VS_POL(VS_POL)) u_vs (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .vsync    (vsync_i),
    .raw_ev   (raw_ev),
    .apply_ev (apply_ev)
  );
  assign commit_pend_o = pend;
  assign shadow_data_o = shd;
  always_comb begin
    wr_ok    = wr_req_i && (32'(wr_ch_i) < NUM_CH);
    force_ev = WD_EN && pend && (wd == TO_MAX);
    do_apply = pend && (apply_ev || force_ev);
  end
  // shadow copies the pre-edge staging, so a same-edge write lands only in staging
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      stg            <= RESET_VAL;
      shd            <= RESET_VAL;
      pend           <= 1'b0;
      wr_ack_o       <= 1'b0;
      update_pulse_o <= 1'b0;
      timeout_o      <= 1'b0;
      frame_cnt_o    <= '0;
      wd             <= '0;
    end else begin
      wr_ack_o       <= wr_ok;
      if (wr_ok) stg[wr_ch_i] <= wr_data_i;
      if (do_apply) shd <= stg;
      update_pulse_o <= do_apply;
      pend           <= commit_req_i || (pend && !do_apply);
      frame_cnt_o    <= frame_cnt_o + 16'(apply_ev);
      // a forced apply that coincides with a delayed one is an ordinary apply
      timeout_o      <= (force_ev && !apply_ev) || (timeout_o && !raw_ev);
      wd             <= (!WD_EN || raw_ev || apply_ev || force_ev) ? '0 : wd + TO_W'(wd != TO_MAX);
    end
endmodule

// File: tb/tb_frame_param_shadow.sv
// tb_frame_param_shadow: scoreboard bench for the frame-synchronous parameter shadow bank
module tb_frame_param_shadow;
  import frame_param_pkg::*;
  localparam logic [59:0] B_RV = {12'd4, DEF_RESET_VAL};
  logic sys_clk = 1'b0, sys_rst_n = 1'b0, vsync = 1'b1;
  logic wr_req = 1'b0, commit = 1'b0;
  logic [1:0] wr_ch = '0;
  logic [11:0] wr_data = '0;
  logic wr_ack, pend, pulse, to;
  logic [47:0] shadow;
  logic [15:0] frame;
  logic b_wr_req = 1'b0, b_commit = 1'b0;
  logic [2:0] b_wr_ch = '0;
  logic [11:0] b_wr_data = '0;
  logic b_ack, b_pend, b_pulse, b_to;
  logic [59:0] b_shadow;
  logic [15:0] b_frame;
  frame_param_shadow #(.NUM_CH(4), .DATA_W(12), .SYNC_DLY(3), .VS_POL(1'b0), .TO_W(24),
    .TIMEOUT(24'd100), .RESET_VAL(DEF_RESET_VAL)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .vsync_i(vsync), .wr_req_i(wr_req),
    .wr_ch_i(wr_ch), .wr_data_i(wr_data), .wr_ack_o(wr_ack), .commit_req_i(commit),
    .commit_pend_o(pend), .shadow_data_o(shadow), .update_pulse_o(pulse),
    .frame_cnt_o(frame), .timeout_o(to));
  frame_param_shadow #(.NUM_CH(5), .DATA_W(12), .SYNC_DLY(3), .VS_POL(1'b0), .TO_W(24),
    .TIMEOUT(24'd0), .RESET_VAL(B_RV)) dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .vsync_i(vsync), .wr_req_i(b_wr_req),
    .wr_ch_i(b_wr_ch), .wr_data_i(b_wr_data), .wr_ack_o(b_ack), .commit_req_i(b_commit),
    .commit_pend_o(b_pend), .shadow_data_o(b_shadow), .update_pulse_o(b_pulse),
    .frame_cnt_o(b_frame), .timeout_o(b_to));
  always #5 sys_clk = ~sys_clk;
  typedef struct {logic [3:0][11:0] sh; int at;} exp_t;
  exp_t sb[$];
  exp_t e_m;
  int cyc = 0, checks = 0, errors = 0, k = 0, last_clr = 0;
  logic [3:0][11:0] stg = DEF_RESET_VAL;
  logic [4:0][11:0] b_exp = B_RV;
  logic [47:0] sh0;
  always @(posedge sys_clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask
  task automatic wr(input int ch, input int d);
    wr_req = 1'b1; wr_ch = 2'(ch); wr_data = 12'(d);
    step(1);
    wr_req = 1'b0;
    chk("wr_ack", wr_ack, 1'b1);
    stg[ch] = 12'(d);
  endtask
  task automatic do_commit();
    commit = 1'b1;
    step(1);
    commit = 1'b0;
    chk("pend_set", pend, 1'b1);
  endtask
  always @(posedge sys_clk) begin
    #1;
    if (pulse) begin
      if (sb.size() == 0) chk("pulse_unexpected", pulse, 1'b0);
      else begin
        e_m = sb.pop_front();
        chk("pulse_cycle", cyc, e_m.at);
        chk("pulse_shadow", shadow, e_m.sh);
      end
    end
  end
  initial begin
    step(3);
    chk("rst_shadow", shadow, DEF_RESET_VAL);
    chk("rst_flags", {wr_ack, pend, pulse, to}, 4'b0);
    chk("rst_frame", frame, 16'd0);
    sys_rst_n = 1'b1;
    step(2);
    wr(CH_X_LEN, 1280);
    wr(CH_Y_LEN, 720);
    do_commit();
    vsync = 1'b0; k = cyc + 1;
    sb.push_back('{stg, k + 3});
    step(3);
    chk("pre_apply_shadow", shadow, DEF_RESET_VAL);
    step(1);
    chk("apply_shadow", shadow, stg);
    chk("apply_pend", pend, 1'b0);
    chk("apply_frame", frame, 16'd1);
    vsync = 1'b1; step(3);
    b_wr_req = 1'b1; b_wr_ch = 3'd5; b_wr_data = 12'd99;
    step(1);
    chk("b_bad_ch_ack", b_ack, 1'b0);
    b_wr_ch = 3'd1; b_wr_data = 12'd33;
    step(1);
    b_wr_req = 1'b0;
    chk("b_ack", b_ack, 1'b1);
    b_exp[1] = 12'd33;
    b_commit = 1'b1; step(1); b_commit = 1'b0;
    sh0 = shadow;
    vsync = 1'b0; step(4);
    chk("nocommit_shadow", shadow, sh0);
    chk("nocommit_frame", frame, 16'd2);
    chk("b_shadow", b_shadow, b_exp);
    chk("b_frame", b_frame, 16'd2);
    vsync = 1'b1; step(2);
    wr(CH_BI_A, 64);
    do_commit();
    vsync = 1'b0; k = cyc + 1;
    sb.push_back('{stg, k + 3});
    step(3);
    wr_req = 1'b1; wr_ch = 2'(CH_BI_A); wr_data = 12'd200; commit = 1'b1;
    step(1);
    wr_req = 1'b0; commit = 1'b0;
    chk("coinc_ack", wr_ack, 1'b1);
    stg[CH_BI_A] = 12'd200;
    chk("coinc_shadow_ch2", shadow[35:24], 12'd64);
    chk("coinc_pend_kept", pend, 1'b1);
    vsync = 1'b1; step(2);
    vsync = 1'b0; k = cyc + 1;
    sb.push_back('{stg, k + 3});
    step(4);
    chk("second_shadow_ch2", shadow[35:24], 12'd200);
    chk("second_frame", frame, 16'd4);
    last_clr = k + 3;
    vsync = 1'b1; step(2);
    wr(CH_OUT_MODEL, 7);
    do_commit();
    chk("wd_to_idle", to, 1'b0);
    sb.push_back('{stg, last_clr + 100});
    step(last_clr + 99 - cyc);
    chk("wd_not_yet", to, 1'b0);
    chk("wd_pend_yet", pend, 1'b1);
    step(1);
    chk("wd_timeout", to, 1'b1);
    chk("wd_shadow", shadow, stg);
    chk("wd_pend", pend, 1'b0);
    chk("wd_frame", frame, 16'd4);
    step(5);
    chk("wd_sticky", to, 1'b1);
    vsync = 1'b0; step(1);
    chk("wd_clear", to, 1'b0);
    step(3);
    chk("final_frame", frame, 16'd5);
    step(2);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
